// File: rtl/regfile_pkg.sv
// Shared constants for the register file slice: instruction field
// positions, default geometry and the index-width helper.
package regfile_pkg;

  // Default geometry of the architectural register file
  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  // Instruction field positions (RISC-V style encoding)
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  // Smallest r such that 2**r >= n; used to size register indices
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flag per register, RAW/WAW hazard
// detection for the instruction currently presented, and the set/clear
// rules that track outstanding destination reservations.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int AW     = log2(NREGS_DEFAULT),
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic             issue,
  input  logic             reg_write,
  input  logic [AW-1:0]    write_reg,
  output logic [NREGS-1:0] busy,
  output logic             stall
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             haz_rd;
  logic             fwd_ok;

  // A source whose pending value is being written right now is not a
  // hazard when forwarding is available; the destination check always
  // accepts a same-cycle write because the reservation is being retired.
  always_comb begin
    fwd_ok  = (BYPASS != 0) && reg_write;
    haz_rs1 = (rs1 != '0) && busy_q[rs1] && !(fwd_ok && (write_reg == rs1));
    haz_rs2 = (rs2 != '0) && busy_q[rs2] && !(fwd_ok && (write_reg == rs2));
    haz_rd  = (rd  != '0) && busy_q[rd]  && !(reg_write && (write_reg == rd));
    stall   = !reset && (haz_rs1 || haz_rs2 || haz_rd);
  end

  // Next flags: the write clears first so an accepted issue to the same
  // index wins; register 0 can never be reserved.
  always_comb begin
    busy_d = busy_q;
    if (reg_write) busy_d[write_reg] = 1'b0;
    if (issue && !stall && (rd != '0)) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Flag storage; reset drops every outstanding reservation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with optional write-to-read
// forwarding, register 0 hardwired to zero, and a scoreboard that
// stalls issue on outstanding-write hazards.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = NREGS_DEFAULT,
  parameter  int BYPASS = 1,
  localparam int AW     = log2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             issue,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteReg,
  input  logic [XLEN-1:0]  WriteData,
  output logic [XLEN-1:0]  ReadData1,
  output logic [XLEN-1:0]  ReadData2,
  output logic             Stall,
  output logic [NREGS-1:0] Busy
);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic            unused_instr;

  // Register indices are the low AW bits of each 5-bit field
  assign rs1 = instruction[RS1_LSB +: AW];
  assign rs2 = instruction[RS2_LSB +: AW];
  assign rd  = instruction[RD_LSB  +: AW];

  // Opcode/funct bits are not needed here
  assign unused_instr = ^instruction;

  // Array write; index 0 is never stored so it always reads as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (RegWrite && (WriteReg != '0)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Combinational reads with optional same-cycle forwarding; outputs are
  // forced to zero while reset is held so an in-flight write cannot leak
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!reset) begin
      if (rs1 != '0) begin
        if ((BYPASS != 0) && RegWrite && (WriteReg == rs1)) ReadData1 = WriteData;
        else                                                ReadData1 = regs[rs1];
      end
      if (rs2 != '0) begin
        if ((BYPASS != 0) && RegWrite && (WriteReg == rs2)) ReadData2 = WriteData;
        else                                                ReadData2 = regs[rs2];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .issue     (issue),
    .reg_write (RegWrite),
    .write_reg (WriteReg),
    .busy      (Busy),
    .stall     (Stall)
  );

endmodule
